// File: rtl/arbiter_new_rr.sv
// arbiter_new_rr: 8-port single-grant arbiter with round-robin or fixed priority and an explicit ack release.
// Optional macro ARB_ACK_TIMEOUT_EN adds an automatic release after TIMEOUT_CYCLES cycles without an ack.
module arbiter_new_rr #(
    parameter int NUM_PORTS = 8
`ifdef ARB_ACK_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_PORTS-1:0]         port_req,
    input  logic                         cfg_arb_scheme,
    input  logic [$clog2(NUM_PORTS)-1:0] ack_port,
    input  logic                         gnt_ack,
    output logic [$clog2(NUM_PORTS)-1:0] gnt_port,
    output logic                         gnt_valid,
    output logic [$clog2(NUM_PORTS)-1:0] high_priority
);
    localparam int IW = $clog2(NUM_PORTS);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state;
    logic [IW-1:0] fixed_sel, rr_sel;
    logic timeout, release_gnt;
    // Candidate winners: scanning from the far end so the nearest hit is written last.
    always_comb begin
        fixed_sel = '0;
        rr_sel = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (port_req[i]) fixed_sel = IW'(i);
            if (port_req[high_priority + IW'(i)]) rr_sel = high_priority + IW'(i);
        end
    end
`ifdef ARB_ACK_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    // Grant-age counter: zero while idle so every grant starts a fresh count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else cnt <= (state == GRANT) ? cnt + CW'(1) : '0;
    end
    assign timeout = (state == GRANT) && (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif
    assign release_gnt = (gnt_ack && ack_port == gnt_port) || timeout;
    // Two-state grant FSM; the release edge never re-grants, forcing an idle cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            gnt_port      <= '0;
            gnt_valid     <= 1'b0;
            high_priority <= '0;
        end else if (state == IDLE) begin
            if (|port_req) begin
                state     <= GRANT;
                gnt_valid <= 1'b1;
                gnt_port  <= cfg_arb_scheme ? rr_sel : fixed_sel;
            end
        end else if (release_gnt) begin
            state     <= IDLE;
            gnt_valid <= 1'b0;
            if (cfg_arb_scheme) high_priority <= gnt_port + IW'(1);
        end
    end
endmodule

// File: tb/tb_arbiter_new_rr.sv
// tb_arbiter_new_rr: directed-vector self-checking bench for arbiter_new_rr.
module tb_arbiter_new_rr;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] port_req = '0;
    logic       cfg_arb_scheme = 1'b1;
    logic [2:0] ack_port = '0;
    logic       gnt_ack = 1'b0;
    logic [2:0] gnt_port;
    logic       gnt_valid;
    logic [2:0] high_priority;
    int errors = 0;
    int checks = 0;

    arbiter_new_rr dut (
        .clk(clk), .reset(reset), .port_req(port_req), .cfg_arb_scheme(cfg_arb_scheme),
        .ack_port(ack_port), .gnt_ack(gnt_ack), .gnt_port(gnt_port),
        .gnt_valid(gnt_valid), .high_priority(high_priority)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [2:0] p, input logic [2:0] hp);
        check({tag, ".valid"}, 8'(gnt_valid), 8'(v));
        check({tag, ".port"}, 8'(gnt_port), 8'(p));
        check({tag, ".hp"}, 8'(high_priority), 8'(hp));
    endtask

    task automatic ack(input logic [2:0] p);
        gnt_ack = 1'b1;
        ack_port = p;
        step();
        gnt_ack = 1'b0;
        ack_port = 3'bx;
    endtask

    initial begin
        step(2);
        expect_out("reset_held", 0, 0, 0);
        reset = 1'b1;
        step(2);
        expect_out("reset_released", 0, 0, 0);
        // RR single request, hold through withdrawal, release advances head
        port_req = 8'h10;
        step();
        expect_out("rr_gnt4", 1, 4, 0);
        port_req = 8'h00;
        step();
        expect_out("rr_hold4", 1, 4, 0);
        ack(4);
        expect_out("rr_rel4", 0, 4, 5);
        // RR search from head 5 wraps only past 7
        port_req = 8'h81;
        step();
        expect_out("rr_gnt7", 1, 7, 5);
        ack(7);
        expect_out("rr_rel7_no_regrant", 0, 7, 0);
        step();
        expect_out("rr_gnt0", 1, 0, 0);
        ack(0);
        expect_out("rr_rel0", 0, 0, 1);
        // Fixed priority: port 0 always wins, head untouched
        cfg_arb_scheme = 1'b0;
        step();
        expect_out("fx_gnt0_a", 1, 0, 1);
        ack(0);
        expect_out("fx_rel0_a", 0, 0, 1);
        step();
        expect_out("fx_gnt0_b", 1, 0, 1);
        ack(0);
        expect_out("fx_rel0_b", 0, 0, 1);
        port_req = 8'h00;
        step();
        expect_out("fx_idle", 0, 0, 1);
        // Mismatched ack ignored, matching ack releases, idle ack ignored
        cfg_arb_scheme = 1'b1;
        port_req = 8'h08;
        step();
        expect_out("rr_gnt3", 1, 3, 1);
        ack(2);
        expect_out("wrong_ack", 1, 3, 1);
        ack(3);
        expect_out("rr_rel3", 0, 3, 4);
        port_req = 8'h00;
        ack(3);
        expect_out("idle_ack", 0, 3, 4);
        // Wrap-around search from head 4 lands on port 1
        port_req = 8'h06;
        step();
        expect_out("rr_wrap1", 1, 1, 4);
        ack(1);
        expect_out("rr_rel1", 0, 1, 2);
        // Scheme change mid-grant: grant holds, release uses fixed rule
        port_req = 8'h41;
        step();
        expect_out("rr_gnt6", 1, 6, 2);
        cfg_arb_scheme = 1'b0;
        step();
        expect_out("cfg_change_hold", 1, 6, 2);
        ack(6);
        expect_out("fx_rel6", 0, 6, 2);
        cfg_arb_scheme = 1'b1;
        // Unacked grant: timeout release or indefinite hold
        port_req = 8'h20;
        step();
        expect_out("rr_gnt5", 1, 5, 2);
        port_req = 8'h00;
`ifdef ARB_ACK_TIMEOUT_EN
        step(15);
        expect_out("to_hold15", 1, 5, 2);
        step();
        expect_out("to_release", 0, 5, 6);
`else
        step(20);
        expect_out("hold_long", 1, 5, 2);
        ack(5);
        expect_out("rr_rel5", 0, 5, 6);
`endif
        // Asynchronous reset mid-grant
        port_req = 8'h04;
        step();
        expect_out("rr_gnt2", 1, 2, 6);
        #2 reset = 1'b0;
        #1;
        expect_out("async_reset", 0, 0, 0);
        step();
        expect_out("reset_still", 0, 0, 0);
        reset = 1'b1;
        port_req = 8'h00;
        step();
        expect_out("after_reset", 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/arbiter_new_rr.md
Name: arbiter_new_rr

Overview:
- 8-requestor grant arbiter with a single outstanding grant, held until explicitly acknowledged.
- Run-time selectable scheme: round-robin or fixed priority.
- Sits between 8 client request lines and a shared resource. Reports the granted port index and the current round-robin head (highest-priority port).

Parameters:
- NUM_PORTS, 8, number of requestors; fixed at 8 for this revision (index width 3).
- TIMEOUT_CYCLES, 16, grant-hold limit used only when ARB_ACK_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- port_req  input  8  request vector; bit i = port i requesting.
- cfg_arb_scheme  input  1  1 = round-robin, 0 = fixed priority (port 0 highest).
- ack_port  input  3  index of the port releasing the grant; qualified by gnt_ack.
- gnt_ack  input  1  release strobe, one cycle.
- gnt_port  output  3  index of the granted port; valid when gnt_valid = 1.
- gnt_valid  output  1  a grant is outstanding.
- high_priority  output  3  round-robin head pointer (highest-priority port for the next arbitration).

Behaviour:
- Reset (reset = 0, async): gnt_port = 0, gnt_valid = 0, high_priority = 0, FSM = IDLE.
- All outputs are registered.
- FSM has two states: IDLE and GRANT.
- IDLE, port_req != 0 at a rising edge:
  - Next state GRANT, gnt_valid = 1, gnt_port = selected index.
  - Latency: request sampled at edge N, grant visible after edge N.
- IDLE, port_req == 0: stay IDLE, outputs hold.
- Selection:
  - cfg_arb_scheme = 0: lowest-index asserted bit wins.
  - cfg_arb_scheme = 1: first asserted bit searching upward from high_priority, wrapping 7 -> 0.
- GRANT:
  - gnt_port and gnt_valid hold regardless of port_req changes, including a withdrawn request.
  - Release condition: gnt_ack = 1 and ack_port == gnt_port at a rising edge.
  - On release: gnt_valid = 0, state IDLE. gnt_port keeps its last value.
  - On release with cfg_arb_scheme = 1: high_priority <= gnt_port + 1 (mod 8).
  - On release with cfg_arb_scheme = 0: high_priority is unchanged.
- gnt_ack with mismatched ack_port, or gnt_ack while IDLE: ignored, no state change.
- ack_port is don't-care (may be X) when gnt_ack = 0.
- No re-grant on the release edge. The next grant comes at the earliest on the following edge, so there is at least one IDLE cycle between grants.
- cfg_arb_scheme is sampled only at arbitration (IDLE edges) and at release. Changing it during GRANT does not disturb the held grant.
- Reset asserted mid-grant: immediate return to reset values; the grant is lost and the pointer returns to 0.

Optional Feature:
- Macro: ARB_ACK_TIMEOUT_EN.
- Defined:
  - A counter runs while in GRANT.
  - If no matching ack arrives within TIMEOUT_CYCLES cycles, the grant auto-releases exactly as a matching ack would, including the pointer advance in round-robin mode.
  - The counter clears on entry to GRANT and on reset.
- Not defined: no counter; the grant is held indefinitely until a matching ack.

Test Plan:
- Reset held low, then released with port_req = 0 -> gnt_valid = 0, gnt_port = 0, high_priority = 0 for all cycles.
- RR mode, port_req = 8'b0001_0000 -> gnt_valid = 1, gnt_port = 4 after the first edge. Drop the request; grant still held. gnt_ack = 1, ack_port = 4 -> gnt_valid = 0, high_priority = 5.
- Continuing: port_req = 8'b1000_0001 with high_priority = 5 -> gnt_port = 7. Ack port 7 -> high_priority = 0. The still-pending port 0 is then granted one cycle after IDLE.
- Fixed mode, port_req = 8'b1000_0001 -> gnt_port = 0 each arbitration. high_priority stays at its prior value across releases.
- Grant on port 3, gnt_ack = 1 with ack_port = 2 -> no release; then ack_port = 3 -> release. gnt_ack while IDLE -> no effect.
- Assert reset mid-grant -> outputs are 0 immediately, without waiting for a clock edge. With ARB_ACK_TIMEOUT_EN defined, an unacked grant releases after 16 cycles.
